// File: rtl/memoria_ram_scan.sv
// memoria_ram_scan: single-port word memory with a manual read/write port,
// a whole-memory clear sequencer, an automatic address-scan mode and a
// multiplexed active-low seven-segment display of the registered read data.
module memoria_ram_scan #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 50_000_000,
    parameter int REF_DIV  = 50_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   dato_write_i,
    input  logic                wren_i,
    input  logic                rden_i,
    input  logic                clear_i,
    input  logic                scan_en_i,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   dato_read_o,
    output logic [0:6]          salida_o,
    output logic [DATA_W/4-1:0] daenable_o
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int DIGITS  = DATA_W / 4;
    localparam int SCAN_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int REF_CW  = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
    localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);
    localparam logic [REF_CW-1:0]  REF_LAST  = REF_CW'(REF_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;

    // Hex digit to active-low segment pattern, bit 0 = segment a.
    function automatic logic [0:6] seg7_f(input logic [3:0] nib);
        logic [0:6] code;
        case (nib)
            4'h0:    code = 7'b0000001;
            4'h1:    code = 7'b1001111;
            4'h2:    code = 7'b0010010;
            4'h3:    code = 7'b0000110;
            4'h4:    code = 7'b1001100;
            4'h5:    code = 7'b0100100;
            4'h6:    code = 7'b0100000;
            4'h7:    code = 7'b0001111;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0000100;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b1100000;
            4'hC:    code = 7'b0110001;
            4'hD:    code = 7'b1000010;
            4'hE:    code = 7'b0110000;
            4'hF:    code = 7'b0111000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [1:0]         state_q,     state_d;
    logic               busy_q,      busy_d;
    logic [ADDR_W-1:0]  clr_ptr_q,   clr_ptr_d;
    logic [ADDR_W-1:0]  scan_ptr_q,  scan_ptr_d;
    logic [SCAN_CW-1:0] step_q,      step_d;
    logic [REF_CW-1:0]  ref_q,       ref_d;
    logic [DIG_W-1:0]   digit_q,     digit_d;
    logic [DATA_W-1:0]  dato_read_q, dato_read_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [0:6]         seg_q,       seg_d;
    logic [DIGITS-1:0]  en_q,        en_d;

    logic               we_raw_s;
    logic               we_s;
    logic [ADDR_W-1:0]  wa_s;
    logic [DATA_W-1:0]  wd_s;
    logic [3:0]         nib_s;

    // Next-state logic for the control FSM, the read path and the clear/scan pointers.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        clr_ptr_d   = clr_ptr_q;
        scan_ptr_d  = scan_ptr_q;
        step_d      = step_q;
        dato_read_d = dato_read_q;
        addr_d      = addr_q;
        we_raw_s    = 1'b0;
        wa_s        = addr_i;
        wd_s        = dato_write_i;

        case (state_q)
            ST_IDLE: begin
                we_raw_s = wren_i;
                // Reading mem_q before the edge gives read-before-write ordering.
                if (rden_i) begin
                    dato_read_d = mem_q[addr_i];
                    addr_d      = addr_i;
                end else begin
                    dato_read_d = dato_read_q;
                    addr_d      = addr_q;
                end
                if (clear_i) begin
                    state_d   = ST_CLEAR;
                    busy_d    = 1'b1;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else if (scan_en_i) begin
                    state_d    = ST_SCAN;
                    scan_ptr_d = {ADDR_W{1'b0}};
                    step_d     = {SCAN_CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                // Manual port is ignored; one word is zeroed per cycle.
                we_raw_s = 1'b1;
                wa_s     = clr_ptr_q;
                wd_s     = {DATA_W{1'b0}};
                if (clr_ptr_q == ADDR_LAST) begin
                    busy_d    = 1'b0;
                    clr_ptr_d = {ADDR_W{1'b0}};
                    if (scan_en_i) begin
                        state_d    = ST_SCAN;
                        scan_ptr_d = {ADDR_W{1'b0}};
                        step_d     = {SCAN_CW{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end

            ST_SCAN: begin
                we_raw_s = wren_i;
                if (step_q == SCAN_LAST) begin
                    step_d      = {SCAN_CW{1'b0}};
                    dato_read_d = mem_q[scan_ptr_q];
                    addr_d      = scan_ptr_q;
                    scan_ptr_d  = scan_ptr_q + ADDR_W'(1);
                end else begin
                    step_d = step_q + SCAN_CW'(1);
                end
                if (clear_i) begin
                    state_d   = ST_CLEAR;
                    busy_d    = 1'b1;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else if (!scan_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset dominates: no memory write is allowed in a reset cycle.
    always_comb begin
        we_s = we_raw_s & ~rst_i;
    end

    // Display refresh timing and registered segment/enable patterns.
    always_comb begin
        ref_d   = ref_q + REF_CW'(1);
        digit_d = digit_q;
        if (ref_q == REF_LAST) begin
            ref_d = {REF_CW{1'b0}};
            if (digit_q == DIG_LAST) begin
                digit_d = {DIG_W{1'b0}};
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end else begin
            ref_d   = ref_q + REF_CW'(1);
            digit_d = digit_q;
        end
        nib_s = 4'(dato_read_q >> {digit_q, 2'b00});
        seg_d = seg7_f(nib_s);
        en_d  = ~(DIGITS'(1) << digit_q);
    end

    // Memory array write port; contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            mem_q[wa_s] <= wd_s;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            clr_ptr_q   <= {ADDR_W{1'b0}};
            scan_ptr_q  <= {ADDR_W{1'b0}};
            step_q      <= {SCAN_CW{1'b0}};
            ref_q       <= {REF_CW{1'b0}};
            digit_q     <= {DIG_W{1'b0}};
            dato_read_q <= {DATA_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            seg_q       <= 7'b0000001;
            en_q        <= ~(DIGITS'(1));
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            clr_ptr_q   <= clr_ptr_d;
            scan_ptr_q  <= scan_ptr_d;
            step_q      <= step_d;
            ref_q       <= ref_d;
            digit_q     <= digit_d;
            dato_read_q <= dato_read_d;
            addr_q      <= addr_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
        end
    end

    assign busy_o      = busy_q;
    assign addr_o      = addr_q;
    assign dato_read_o = dato_read_q;
    assign salida_o    = seg_q;
    assign daenable_o  = en_q;

endmodule

// File: tb/tb_memoria_ram_scan.sv
// Scoreboard bench for memoria_ram_scan: stimulus pushes expected read-port
// values per cycle, a negedge monitor pops and compares them and also checks
// busy_o and the display outputs against a cycle-count model.
module tb_memoria_ram_scan;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int SD    = 4;
    localparam int RD    = 2;
    localparam int DEPTH = 16;
    localparam int DIG   = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] dato_write_i;
    logic          wren_i;
    logic          rden_i;
    logic          clear_i;
    logic          scan_en_i;
    logic          busy_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] dato_read_o;
    logic [0:6]    salida_o;
    logic [DIG-1:0] daenable_o;

    memoria_ram_scan #(
        .ADDR_W(AW), .DATA_W(DW), .SCAN_DIV(SD), .REF_DIV(RD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .dato_write_i(dato_write_i),
        .wren_i(wren_i), .rden_i(rden_i), .clear_i(clear_i), .scan_en_i(scan_en_i),
        .busy_o(busy_o), .addr_o(addr_o), .dato_read_o(dato_read_o),
        .salida_o(salida_o), .daenable_o(daenable_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [0:6]    seg_tab [16];
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    logic [DW-1:0] prev_dato;
    int            cyc = 0;
    int            k_rst = 0;
    bit            rst_seen = 1'b0;
    int            clr_lo = -1;
    int            clr_hi = -2;
    int            n_checks = 0;
    int            n_pass = 0;
    bit            end_req = 1'b0;

    // Cycle count and cycles-since-reset counter used by the display model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_i) begin
            k_rst    <= 0;
            rst_seen <= 1'b1;
        end else begin
            k_rst <= k_rst + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    // Monitor: compare everything the DUT presents on each falling edge.
    always @(negedge clk) begin
        int            ed;
        logic [3:0]    nib;
        logic [DIG-1:0] een;
        exp_t          e;
        if (rst_seen) begin
            chk("busy", {31'd0, busy_o}, {31'd0, (cyc >= clr_lo && cyc <= clr_hi)});
            if (k_rst == 0) begin
                ed  = 0;
                nib = 4'h0;
            end else begin
                ed  = ((k_rst - 1) / RD) % DIG;
                nib = prev_dato[ed*4 +: 4];
            end
            een     = '1;
            een[ed] = 1'b0;
            chk("daenable", {30'd0, daenable_o}, {30'd0, een});
            chk("salida", {25'd0, salida_o}, {25'd0, seg_tab[nib]});
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (e.due < cyc) begin
                    chk("late_item", e.due, cyc);
                end else begin
                    chk("addr_o", {28'd0, addr_o}, {28'd0, e.a});
                    chk("dato_read_o", {24'd0, dato_read_o}, {24'd0, e.d});
                end
            end
        end
        if (end_req) begin
            chk("queue_drained", sbq.size(), 0);
            end_req = 1'b0;
        end
        prev_dato = dato_read_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int due, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.due = due;
        e.a   = a;
        e.d   = d;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        last_a = '0;
        last_d = '0;
        push_exp(cyc + 1, last_a, last_d);
        if (clr_hi > cyc) clr_hi = cyc;
        step();
        rst_i = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_i = a; dato_write_i = d; wren_i = 1'b1;
        push_exp(cyc + 1, last_a, last_d);
        model_mem[a] = d;
        step();
        wren_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        addr_i = a; rden_i = 1'b1;
        last_a = a;
        last_d = model_mem[a];
        push_exp(cyc + 1, last_a, last_d);
        step();
        rden_i = 1'b0;
    endtask

    task automatic do_rw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_i = a; dato_write_i = d; wren_i = 1'b1; rden_i = 1'b1;
        last_a = a;
        last_d = model_mem[a];
        push_exp(cyc + 1, last_a, last_d);
        model_mem[a] = d;
        step();
        wren_i = 1'b0; rden_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(cyc + 1, last_a, last_d);
            step();
        end
    endtask

    // Request a clear; busy is expected for the 16 cycles after acceptance.
    task automatic start_clear(input bit with_scan);
        clear_i = 1'b1; scan_en_i = with_scan;
        clr_lo = cyc + 1;
        clr_hi = cyc + DEPTH;
        push_exp(cyc + 1, last_a, last_d);
        step();
        clear_i = 1'b0;
    endtask

    // Random manual-port activity that the clear sequence must ignore.
    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            wren_i = 1'($urandom_range(0, 1));
            rden_i = 1'($urandom_range(0, 1));
            clear_i = 1'($urandom_range(0, 1));
            addr_i = AW'($urandom_range(0, DEPTH - 1));
            dato_write_i = DW'($urandom);
            push_exp(cyc + 1, last_a, last_d);
            step();
        end
        wren_i = 1'b0; rden_i = 1'b0; clear_i = 1'b0;
    endtask

    // Scan from entry edge e_edge: a load every SD cycles at addresses 0,1,2,...
    task automatic scan_run(input int e_edge, input int ncyc);
        int it = 0;
        int s;
        logic [AW-1:0] wa;
        while (1) begin
            s = cyc + 1 - e_edge;
            if (it >= ncyc && (s % SD) == 2) begin
                scan_en_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0;
                push_exp(cyc + 1, last_a, last_d);
                step();
                break;
            end
            if (s > 0 && (s % SD) == 0) begin
                last_a = AW'((s / SD - 1) % DEPTH);
                last_d = model_mem[last_a];
            end
            push_exp(cyc + 1, last_a, last_d);
            rden_i = 1'($urandom_range(0, 1));
            addr_i = AW'($urandom_range(0, DEPTH - 1));
            wren_i = ($urandom_range(0, 2) == 0);
            if (wren_i) begin
                wa = (it % 5 == 0) ? AW'(s / SD) : addr_i;
                addr_i = wa;
                dato_write_i = DW'($urandom);
                model_mem[wa] = dato_write_i;
            end
            step();
            it++;
        end
        wren_i = 1'b0; rden_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_edge;
        int n_zeroed;
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
        rst_i = 1'b0; addr_i = '0; dato_write_i = '0; wren_i = 1'b0;
        rden_i = 1'b0; clear_i = 1'b0; scan_en_i = 1'b0;

        do_reset();
        do_reset();
        idle(2);

        // Basic write then read; display shows 5 then A.
        do_write(4'd3, 8'hA5);
        do_read(4'd3);
        idle(6);

        // Read-before-write on a shared address.
        do_write(4'd7, 8'h22);
        do_rw(4'd7, 8'h11);
        do_read(4'd7);
        idle(3);

        // Random fill and random traffic.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom));
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       do_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
                1:       do_read(AW'($urandom_range(0, DEPTH - 1)));
                default: do_rw(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            endcase
        end

        // Full clear over a memory of 0xFF.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 8'hFF);
        start_clear(1'b0);
        junk(DEPTH);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i));

        // Scan with mem[i] = i.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(i));
        scan_en_i = 1'b1;
        push_exp(cyc + 1, last_a, last_d);
        e_edge = cyc + 1;
        step();
        scan_run(e_edge, SD * (DEPTH + 1) + 2);
        do_read(4'd5);
        idle(2);

        // Reset in the 6th busy cycle of a clear.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom_range(1, 255)));
        start_clear(1'b0);
        junk(5);
        n_zeroed = (cyc + 1) - (clr_lo + 1);
        for (int i = 0; i < n_zeroed; i++) model_mem[i] = '0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i));

        // Clear and scan requested together: clear first, then scan from 0.
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom_range(1, 255)));
        start_clear(1'b1);
        junk(DEPTH);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        e_edge = clr_hi + 1;
        scan_run(e_edge, SD * 6);
        do_read(4'd0);
        idle(3);

        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memoria_ram_scan.md
MEMORIA_RAM_SCAN -- requirements
Module: memoria_ram_scan

Interface
REQ-001 The module SHALL take these parameters (name, default, meaning):
- ADDR_W, 4: address width; depth is 2**ADDR_W words.
- DATA_W, 8: word width; legal values are 4, 8, 12 and 16; DIGITS = DATA_W/4.
- SCAN_DIV, 50_000_000: clk_i cycles per scan step.
- REF_DIV, 50_000: clk_i cycles per display digit slot.
REQ-002 clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge, with no derived clocks.
REQ-003 rst_i, input, 1 bit: reset; synchronous and active-high.
REQ-004 addr_i, input, ADDR_W bits: manual read/write address.
REQ-005 dato_write_i, input, DATA_W bits: write data.
REQ-006 wren_i, input, 1 bit: write enable, active when high.
REQ-007 rden_i, input, 1 bit: manual read enable, active when high.
REQ-008 clear_i, input, 1 bit: request to zero the whole memory; sampled as a level.
REQ-009 scan_en_i, input, 1 bit: automatic address-scan mode request.
REQ-010 busy_o, output, 1 bit: high while a clear is in progress.
REQ-011 addr_o, output, ADDR_W bits: address of the last completed read.
REQ-012 dato_read_o, output, DATA_W bits: registered read data.
REQ-013 salida_o, output, [0:6]: segments a..g, active-low.
REQ-014 daenable_o, output, DIGITS bits: one-hot digit enable, active-low.

Function
REQ-015 The control FSM SHALL have three states: IDLE, CLEAR and SCAN.
REQ-016 Transition priority SHALL be clear_i over scan_en_i: from IDLE or SCAN, clear_i=1 enters CLEAR on the next edge; otherwise IDLE goes to SCAN when scan_en_i=1, and SCAN goes to IDLE when scan_en_i=0.
REQ-017 In IDLE, wren_i=1 SHALL write dato_write_i to mem[addr_i] at the clock edge.
REQ-018 In IDLE, rden_i=1 SHALL load mem[addr_i] into dato_read_o and addr_i into addr_o at the next edge (1-cycle latency); with rden_i=0 both outputs hold.
REQ-019 When a read and a write hit the same address in the same cycle, the read SHALL return the old data (read-before-write).
REQ-020 CLEAR behaviour:
- A clear pointer starts at 0.
- One word is written with 0 per cycle, over 2**ADDR_W cycles.
- busy_o=1 from the cycle after clear_i is accepted through the final write.
- wren_i, rden_i and clear_i are ignored while in CLEAR.
- After writing the last address, the FSM goes to SCAN if scan_en_i=1, else to IDLE, and busy_o drops in the same cycle.
REQ-021 On entering SCAN, the scan pointer and the step counter SHALL be set to 0.
REQ-022 In SCAN, each time the step counter reaches SCAN_DIV-1 it SHALL wrap to 0, load dato_read_o with mem[ptr] and addr_o with ptr, and increment ptr, wrapping from 2**ADDR_W-1 to 0.
REQ-023 In SCAN, wren_i SHALL still write at addr_i and rden_i SHALL be ignored; a write to the address being scanned in the same cycle returns the old data.
REQ-024 The display refresh counter SHALL run freely in every state; each time it reaches REF_DIV-1, the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-025 When the digit index is k, daenable_o SHALL have bit k low and all other bits high, and salida_o SHALL show the hex digit dato_read_o[4k+3:4k].
REQ-026 Segment codes for salida_o[0:6], active-low:
- 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
- 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
- 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
- C = 0110001, d = 1000010, E = 0110000, F = 0111000
REQ-027 salida_o and daenable_o SHALL be registered (one cycle after the digit index or data changes) and glitch-free.

Reset
REQ-028 When rst_i=1 at a clock edge, the block SHALL set:
- state = IDLE
- busy_o = 0
- dato_read_o = 0 and addr_o = 0
- scan pointer, clear pointer and all counters = 0
- digit index = 0
- daenable_o = all ones except bit 0 = 0
- salida_o = 0000001
REQ-029 Reset SHALL NOT alter memory contents.
REQ-030 A reset asserted mid-CLEAR SHALL abort the clear and leave the already-zeroed words zeroed.
REQ-031 rst_i SHALL dominate all other inputs in the same cycle.

Verification (ADDR_W=4, DATA_W=8, SCAN_DIV=4, REF_DIV=2)
REQ-032 Write 0xA5 to address 3, then pulse rden_i with addr_i=3 -> next cycle dato_read_o=0xA5 and addr_o=3; digit 0 shows 5 (0100100), digit 1 shows A (0001000).
REQ-033 Write 0x11 to address 7 while reading address 7 in the same cycle (address 7 previously 0x22) -> that read returns 0x22; the following read returns 0x11.
REQ-034 Fill all 16 words with 0xFF, then pulse clear_i for 1 cycle -> busy_o high for exactly 16 cycles and no manual writes accepted meanwhile; afterwards reads of all 16 addresses return 0x00.
REQ-035 Raise scan_en_i with mem[i]=i -> every 4 cycles addr_o steps 0,1,...,15,0 and dato_read_o equals addr_o; dropping scan_en_i returns the FSM to IDLE the next cycle.
REQ-036 Assert rst_i on the 6th cycle of a clear -> busy_o=0 and all outputs at reset values next cycle; addresses 0..4 read 0x00 and addresses 5..15 keep their prior data.
REQ-037 Raise scan_en_i and clear_i together -> CLEAR runs first, then SCAN starts at address 0.
